// File: rtl/pit_if.sv
// Host-side signal bundle for the programmable interval timer: strobes from the
// I/O address decoder, write/read data, and the timer interrupt request.
interface pit_if #(
  parameter int WIDTH = 16
);
  logic             tick_en;
  logic             pit0w;
  logic             pit1w;
  logic             pit0r;
  logic             pit1r;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_oe;
  logic             tint;

  modport master (
    output tick_en, pit0w, pit1w, pit0r, pit1r, din,
    input  dout, dout_oe, tint
  );

  modport slave (
    input  tick_en, pit0w, pit1w, pit0r, pit1r, din,
    output dout, dout_oe, tint
  );
endinterface

// File: rtl/pit_timer.sv
// Programmable interval timer: PIT0 prescaler feeding a PIT1 divider, emitting a
// one-cycle tint every (PIT0+1)*(PIT1+1) enabled ticks; PIT0 reload of 0 stops it.
module pit_timer #(
  parameter int WIDTH = 16
) (
  input  logic  sys_clk,
  input  logic  reset,
  pit_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] reload0_q, reload0_d;
  logic [WIDTH-1:0] reload1_q, reload1_d;
  logic [WIDTH-1:0] cnt0_q, cnt0_d;
  logic [WIDTH-1:0] cnt1_q, cnt1_d;
  logic             tint_q, tint_d;
  logic             run;
  logic             step0;
  logic             wrap0;
  logic [WIDTH-1:0] rdata;

  always_comb begin
    reload0_d = reload0_q;
    reload1_d = reload1_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    tint_d    = 1'b0;

    run   = (reload0_q != '0);
    // A PIT0 write swallows the prescaler tick, so the divider cannot step either.
    step0 = run && bus.tick_en && !bus.pit0w;
    wrap0 = step0 && (cnt0_q == '0);

    if (step0) begin
      cnt0_d = wrap0 ? reload0_q : (cnt0_q - ONE);
    end

    if (wrap0 && !bus.pit1w) begin
      if (cnt1_q != '0) begin
        cnt1_d = cnt1_q - ONE;
      end else begin
        cnt1_d = reload1_q;
        tint_d = 1'b1;
      end
    end

    if (bus.pit0w) begin
      reload0_d = bus.din;
      cnt0_d    = bus.din;
    end

    if (bus.pit1w) begin
      reload1_d = bus.din;
      cnt1_d    = bus.din;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      reload0_q <= '0;
      reload1_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      tint_q    <= 1'b0;
    end else begin
      reload0_q <= reload0_d;
      reload1_q <= reload1_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      tint_q    <= tint_d;
    end
  end

  // Reads show the live (pre-edge) counts; both strobes OR the two counts together.
  always_comb begin
    rdata = '0;
    if (bus.pit0r) begin
      rdata = rdata | cnt0_q;
    end
    if (bus.pit1r) begin
      rdata = rdata | cnt1_q;
    end
  end

  assign bus.dout    = rdata;
  assign bus.dout_oe = bus.pit0r | bus.pit1r;
  assign bus.tint    = tint_q;

endmodule

// File: tb/tb_pit_timer.sv
// Scoreboard bench for pit_timer: directed stimulus queues expected read data and
// expected tint cycle numbers; a negedge monitor pops and compares them.
module tb_pit_timer;

  logic sys_clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   base;

  logic [15:0] rd_q[$];
  int          tint_q[$];

  pit_if #(.WIDTH(16)) bus ();

  pit_timer #(.WIDTH(16)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: checks every output the DUT presents against the queued expectations.
  always @(negedge sys_clk) begin
    logic [15:0] exp_d;
    int          exp_c;
    n_cmp++;
    if (bus.dout_oe !== (bus.pit0r | bus.pit1r)) begin
      n_bad++;
      $display("FAIL dout_oe cyc=%0d: got %b expected %b", cyc, bus.dout_oe, bus.pit0r | bus.pit1r);
    end
    if (!bus.pit0r && !bus.pit1r) begin
      n_cmp++;
      if (bus.dout !== 16'h0000) begin
        n_bad++;
        $display("FAIL dout_idle cyc=%0d: got %h expected 0000", cyc, bus.dout);
      end
    end
    if (bus.dout_oe === 1'b1) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL read_unexpected cyc=%0d: got %h expected no read", cyc, bus.dout);
      end else begin
        exp_d = rd_q.pop_front();
        if (bus.dout !== exp_d) begin
          n_bad++;
          $display("FAIL read cyc=%0d: got %h expected %h", cyc, bus.dout, exp_d);
        end
      end
    end
    if (bus.tint !== 1'b0) begin
      n_cmp++;
      if (tint_q.size() == 0) begin
        n_bad++;
        $display("FAIL tint_unexpected cyc=%0d: got %b expected 0", cyc, bus.tint);
      end else begin
        exp_c = tint_q.pop_front();
        if (cyc != exp_c) begin
          n_bad++;
          $display("FAIL tint_cycle: got cycle %0d expected cycle %0d", cyc, exp_c);
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [15:0] val);
    bus.din = val;
    if (sel) bus.pit1w = 1'b1;
    else     bus.pit0w = 1'b1;
    step();
    bus.pit0w = 1'b0;
    bus.pit1w = 1'b0;
  endtask

  task automatic rd(input bit r0, input bit r1, input logic [15:0] exp_v);
    bus.pit0r = r0;
    bus.pit1r = r1;
    rd_q.push_back(exp_v);
    step();
    bus.pit0r = 1'b0;
    bus.pit1r = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.tick_en = 1'b0;
    bus.pit0w = 1'b0;
    bus.pit1w = 1'b0;
    bus.pit0r = 1'b0;
    bus.pit1r = 1'b0;
    bus.din = 16'h0000;

    // Reset state
    repeat (2) step();
    rd(1, 1, 16'h0000);
    reset = 1'b0;
    rd(1, 0, 16'h0000);
    rd(0, 1, 16'h0000);

    // PIT1=2, PIT0=3: period 12, prescaler reads 3,2,1,0,3,2
    bus.tick_en = 1'b1;
    wr(1, 16'd2);
    base = cyc;
    wr(0, 16'd3);
    tint_q.push_back(base + 13);
    tint_q.push_back(base + 25);
    tint_q.push_back(base + 37);
    rd(1, 0, 16'd3);
    rd(1, 0, 16'd2);
    rd(1, 0, 16'd1);
    rd(1, 0, 16'd0);
    rd(1, 0, 16'd3);
    rd(1, 0, 16'd2);
    while (cyc < base + 38) step();
    wr(0, 16'd0);

    // PIT0=1, PIT1=0 with tick_en on alternate cycles: tint every 4 cycles
    bus.tick_en = 1'b0;
    wr(1, 16'd0);
    base = cyc;
    wr(0, 16'd1);
    tint_q.push_back(base + 4);
    tint_q.push_back(base + 8);
    tint_q.push_back(base + 12);
    tint_q.push_back(base + 16);
    for (int i = 1; i <= 16; i++) begin
      bus.tick_en = (i % 2) == 1;
      step();
    end
    bus.tick_en = 1'b0;
    wr(0, 16'd0);

    // PIT0=5, PIT1=5; stop exactly when the expiry would fire
    bus.tick_en = 1'b1;
    wr(1, 16'd5);
    base = cyc;
    wr(0, 16'd5);
    while (cyc < base + 20) step();
    rd(0, 1, 16'd2);
    while (cyc < base + 36) step();
    wr(0, 16'd0);
    repeat (10) step();
    rd(0, 1, 16'd0);
    rd(1, 0, 16'd0);
    wr(1, 16'd9);
    repeat (3) step();
    rd(0, 1, 16'd9);

    // PIT1 write collides with a prescaler wrap while cnt1==0
    wr(1, 16'd0);
    base = cyc;
    wr(0, 16'd2);
    tint_q.push_back(base + 4);
    while (cyc < base + 6) step();
    bus.din = 16'd7;
    bus.pit1w = 1'b1;
    bus.pit1r = 1'b1;
    rd_q.push_back(16'd0);
    step();
    bus.pit1w = 1'b0;
    bus.pit1r = 1'b0;
    rd(1, 0, 16'd2);
    rd(0, 1, 16'd7);
    wr(0, 16'd0);

    // Combined read of both counters, then idle bus
    bus.tick_en = 1'b0;
    wr(1, 16'h000F);
    wr(0, 16'h00F0);
    rd(1, 1, 16'h00FF);
    rd(1, 0, 16'h00F0);
    rd(0, 1, 16'h000F);
    step();
    wr(0, 16'h0000);

    // Reset asserted while a tint is registered: it must vanish at once
    bus.tick_en = 1'b1;
    wr(1, 16'd0);
    base = cyc;
    wr(0, 16'd1);
    tint_q.push_back(base + 3);
    while (cyc < base + 5) step();
    reset = 1'b1;
    rd(1, 0, 16'h0000);
    rd(0, 1, 16'h0000);
    reset = 1'b0;
    rd(1, 1, 16'h0000);
    repeat (1000) step();
    rd(1, 0, 16'h0000);
    rd(0, 1, 16'h0000);

    repeat (3) step();
    n_cmp++;
    if (tint_q.size() != 0) begin
      n_bad++;
      $display("FAIL tint_missing: got %0d pending expected 0 pending", tint_q.size());
    end
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL read_missing: got %0d pending expected 0 pending", rd_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
